dbg_reg_access: RTL and testbench
=================================

Name: dbg_reg_access

Overview:
Debug-side register access engine: the initiator end of the register file's debug write port and one read port. Accepts debug read/write commands over a valid/ready channel and performs the register-file access only while the core is halted. Returns data/status on a valid/ready response channel. Sits between the debug module and the register file.

Parameters:
N_REGS, 32, number of implemented registers; addresses >= N_REGS are errors
REG_WIDTH, rv32_isa::RegWidth (32), data width
ADDR_WIDTH, rv32_isa::RegAddrWidth (5), register address width

Ports:
iClk  input  1  clock
iRst  input  1  asynchronous active-high reset
iHalted  input  1  core halted; register access permitted only when high
iCmdValid  input  1  command valid
oCmdReady  output  1  command accepted when iCmdValid & oCmdReady at rising edge
iCmdWrite  input  1  1=write, 0=read
iCmdAddr  input  ADDR_WIDTH  target register
iCmdData  input  REG_WIDTH  write data
oRspValid  output  1  response valid
iRspReady  input  1  response consumed when oRspValid & iRspReady
oRspData  output  REG_WIDTH  read data (write: 0, or readback value under the optional feature)
oRspErr  output  1  1 = not halted or address out of range
oWriteEn_dbg  output  1  register-file debug write enable
oRd_dbg  output  reg_transport_t  debug write {addr, value}
oAddrRs  output  ADDR_WIDTH  register-file read address
iRs  input  REG_WIDTH  register-file read data (combinational from oAddrRs)
oBusy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, iRst=1): state=IDLE, oCmdReady=1, oRspValid=0, oRspErr=0, oRspData=0, oWriteEn_dbg=0, oRd_dbg=0, oAddrRs=0, oBusy=0. Latched command is cleared.
- States: IDLE, READ, WRITE, RBACK (optional feature only), RESP.
- IDLE: oCmdReady=1. On accept, latch write, addr and data.
  - Error check at accept: iHalted=0 or addr>=N_REGS -> RESP with oRspErr=1, oRspData=0, no register access.
  - Otherwise -> READ or WRITE.
- READ: one cycle. oAddrRs=latched addr. iRs is captured into oRspData at the end of the cycle. Then -> RESP.
- WRITE: one cycle. oWriteEn_dbg=1 and oRd_dbg={latched addr, latched data}; the register file commits at the end of this cycle. Then -> RESP (or RBACK). oWriteEn_dbg is 0 in every other state.
- Write to x0: performed on the port as normal (the register file ignores it). No error.
- RESP: oRspValid=1. oRspData and oRspErr are held stable until the handshake completes. On iRspReady=1 -> IDLE. oCmdReady=0 throughout.
- Latency from command accept edge to oRspValid: read 2 cycles, write 2 cycles, error 1 cycle.
- Throughput: at most one command in flight; the next command is accepted no earlier than the cycle after the response handshake.
- iHalted falling after accept: the in-flight access completes. Halt is checked only at accept.
- oAddrRs holds the last value when not in READ or RBACK.
- Reset mid-operation: the operation is abandoned immediately. A write aborted before its WRITE cycle is never issued. No response is produced.

Optional Feature:
DBG_REG_READBACK_EN
- Defined: after WRITE the FSM enters RBACK. RBACK is one cycle with oAddrRs=latched addr, and iRs is captured into oRspData. Write latency becomes 3 cycles. A mismatch against the written data is not an error; x0 returns 0.
- Undefined: RBACK does not exist, write responses carry oRspData=0, and the write latency is 2 cycles.

Decomposition:
- Package dbg_access_pkg holds:
  - state enum dbg_state_t {IDLE, READ, WRITE, RBACK, RESP};
  - struct dbg_cmd_t {write, addr, data} used for the latched command.
- The module reuses reg_transport::reg_transport_t and the rv32_isa widths.
- No sub-module: a single FSM plus a response register.

Test Plan:
- Halted; write addr 5 data 0xDEADBEEF -> oWriteEn_dbg high for exactly 1 cycle with oRd_dbg={5,0xDEADBEEF}; oRspValid 2 cycles after accept, oRspErr=0. Then read addr 5 -> oRspData=0xDEADBEEF at 2-cycle latency.
- iHalted=0; write addr 3 -> oRspValid next cycle with oRspErr=1, oRspData=0, oWriteEn_dbg never asserted.
- N_REGS=16; read addr 20 while halted -> oRspErr=1, oRspData=0, 1-cycle latency.
- Hold iRspReady=0 for 5 cycles during a read of 0x12345678 -> oRspValid, oRspData and oRspErr stable; oCmdReady=0 and a pending iCmdValid is not accepted. On release -> IDLE, next command accepted the following cycle.
- Assert iRst in the cycle after accepting a write -> no oWriteEn_dbg pulse, oRspValid=0, back in IDLE with oCmdReady=1.
- DBG_REG_READBACK_EN defined; write addr 0 data 0xFFFFFFFF -> RBACK visited, oRspData=0, oRspValid 3 cycles after accept.

Source files
------------

// File: rtl/dbg_access_pkg.sv
// Types for the debug register access engine.
package dbg_access_pkg;

   import rv32_isa::*;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      WRITE = 3'd2,
      RBACK = 3'd3,
      RESP  = 3'd4
   } dbg_state_t;

   typedef struct packed {
      logic                    write;
      logic [RegAddrWidth-1:0] addr;
      logic [RegWidth-1:0]     data;
   } dbg_cmd_t;

endpackage : dbg_access_pkg

// File: rtl/reg_transport.sv
// Register-file write transport payload {addr, value}.
package reg_transport;

   import rv32_isa::*;

   typedef struct packed {
      logic [RegAddrWidth-1:0] addr;
      logic [RegWidth-1:0]     value;
   } reg_transport_t;

endpackage : reg_transport

// File: rtl/rv32_isa.sv
// RV32 architectural widths shared by the register-file blocks.
package rv32_isa;

   localparam int unsigned RegWidth     = 32;
   localparam int unsigned RegAddrWidth = 5;

endpackage : rv32_isa

// File: rtl/dbg_reg_access.sv
// Debug register access engine: performs one register-file read or write per
// debug command while the core is halted and returns data/status.
// Optional feature macro: DBG_REG_READBACK_EN (read back the written register
// after a write and return it in the response).
module dbg_reg_access
   import dbg_access_pkg::*;
   import reg_transport::*;
#(
   parameter int unsigned N_REGS     = 32,
   parameter int unsigned REG_WIDTH  = rv32_isa::RegWidth,
   parameter int unsigned ADDR_WIDTH = rv32_isa::RegAddrWidth
) (
   input  logic                  iClk,
   input  logic                  iRst,
   input  logic                  iHalted,
   input  logic                  iCmdValid,
   output logic                  oCmdReady,
   input  logic                  iCmdWrite,
   input  logic [ADDR_WIDTH-1:0] iCmdAddr,
   input  logic [REG_WIDTH-1:0]  iCmdData,
   output logic                  oRspValid,
   input  logic                  iRspReady,
   output logic [REG_WIDTH-1:0]  oRspData,
   output logic                  oRspErr,
   output logic                  oWriteEn_dbg,
   output reg_transport_t        oRd_dbg,
   output logic [ADDR_WIDTH-1:0] oAddrRs,
   input  logic [REG_WIDTH-1:0]  iRs,
   output logic                  oBusy
);

   dbg_state_t            r_state;
   dbg_state_t            w_next_state;
   dbg_cmd_t              r_cmd;
   logic [REG_WIDTH-1:0]  r_rsp_data;
   logic                  r_rsp_err;
   logic [ADDR_WIDTH-1:0] r_addr_rs;
   logic                  w_accept;
   logic                  w_cmd_err;

   assign w_accept  = iCmdValid & oCmdReady;
   // Halt and address range are only judged at the moment of acceptance.
   assign w_cmd_err = ~iHalted | (32'(iCmdAddr) >= N_REGS);

   assign oRspData  = r_rsp_data;
   assign oRspErr   = r_rsp_err;
   assign oAddrRs   = r_addr_rs;

   // State register.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) r_state <= IDLE;
      else      r_state <= w_next_state;
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_cmd_err)      w_next_state = RESP;
               else if (iCmdWrite) w_next_state = WRITE;
               else                w_next_state = READ;
            end
         end
         READ:  w_next_state = RESP;
`ifdef DBG_REG_READBACK_EN
         WRITE: w_next_state = RBACK;
`else
         WRITE: w_next_state = RESP;
`endif
         RBACK: w_next_state = RESP;
         RESP:  if (iRspReady) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Handshake and register-file write port decode.
   always_comb begin
      oCmdReady    = 1'b0;
      oRspValid    = 1'b0;
      oWriteEn_dbg = 1'b0;
      oRd_dbg      = '0;
      oBusy        = (r_state != IDLE);
      case (r_state)
         IDLE:  oCmdReady = 1'b1;
         WRITE: begin
            oWriteEn_dbg  = r_cmd.write;
            oRd_dbg.addr  = r_cmd.addr;
            oRd_dbg.value = r_cmd.data;
         end
         RESP:  oRspValid = 1'b1;
         default: ;
      endcase
   end

   // Command latch, read address and response registers.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         r_cmd      <= '0;
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
         r_addr_rs  <= '0;
      end else begin
         if (w_accept) begin
            r_cmd.write <= iCmdWrite;
            r_cmd.addr  <= iCmdAddr;
            r_cmd.data  <= iCmdData;
            r_rsp_data  <= '0;
            r_rsp_err   <= w_cmd_err;
            if (!w_cmd_err && !iCmdWrite) r_addr_rs <= iCmdAddr;
         end
         if (r_state == READ) r_rsp_data <= iRs;
`ifdef DBG_REG_READBACK_EN
         if (r_state == WRITE) r_addr_rs  <= r_cmd.addr;
         if (r_state == RBACK) r_rsp_data <= iRs;
`endif
      end
   end

endmodule : dbg_reg_access

// File: tb/tb_dbg_reg_access.sv
// Self-checking bench for dbg_reg_access with a behavioural register file
// and a reference model of the expected architectural register contents.
module tb_dbg_reg_access;

   import reg_transport::*;

   localparam int unsigned N_REGS = 16;

   logic           iClk = 1'b0;
   logic           iRst = 1'b1;
   logic           iHalted = 1'b0;
   logic           iCmdValid = 1'b0;
   logic           oCmdReady;
   logic           iCmdWrite = 1'b0;
   logic [4:0]     iCmdAddr = '0;
   logic [31:0]    iCmdData = '0;
   logic           oRspValid;
   logic           iRspReady = 1'b0;
   logic [31:0]    oRspData;
   logic           oRspErr;
   logic           oWriteEn_dbg;
   reg_transport_t oRd_dbg;
   logic [4:0]     oAddrRs;
   logic [31:0]    iRs;
   logic           oBusy;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // Register file seen by the DUT and write-port observation.
   logic [31:0] rf     [32] = '{default: '0};
   logic [31:0] exp_rf [32] = '{default: '0};
   int unsigned n_wr = 0;
   logic [4:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;

   always #5 iClk = ~iClk;

   dbg_reg_access #(.N_REGS(N_REGS)) dut (
      .iClk(iClk), .iRst(iRst), .iHalted(iHalted),
      .iCmdValid(iCmdValid), .oCmdReady(oCmdReady), .iCmdWrite(iCmdWrite),
      .iCmdAddr(iCmdAddr), .iCmdData(iCmdData),
      .oRspValid(oRspValid), .iRspReady(iRspReady), .oRspData(oRspData),
      .oRspErr(oRspErr), .oWriteEn_dbg(oWriteEn_dbg), .oRd_dbg(oRd_dbg),
      .oAddrRs(oAddrRs), .iRs(iRs), .oBusy(oBusy)
   );

   assign iRs = (oAddrRs == 5'd0) ? 32'd0 : rf[oAddrRs];

   always @(posedge iClk) begin
      if (oWriteEn_dbg) begin
         n_wr    <= n_wr + 1;
         wr_addr <= oRd_dbg.addr;
         wr_data <= oRd_dbg.value;
         if (oRd_dbg.addr != 5'd0) rf[oRd_dbg.addr] <= oRd_dbg.value;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one command, measure latency, optionally stall the response.
   task automatic do_cmd(input logic wr, input int unsigned addr, input logic [31:0] data,
                         input logic halted, input int unsigned stall);
      int unsigned lat, exp_lat, n_wr0;
      logic        exp_err;
      logic [31:0] exp_data;
      exp_err = !halted || (addr >= N_REGS);
      if (exp_err) begin
         exp_lat = 1; exp_data = 32'd0;
      end else if (wr) begin
`ifdef DBG_REG_READBACK_EN
         exp_lat = 3; exp_data = (addr == 0) ? 32'd0 : data;
`else
         exp_lat = 2; exp_data = 32'd0;
`endif
      end else begin
         exp_lat = 2; exp_data = (addr == 0) ? 32'd0 : exp_rf[addr];
      end

      @(negedge iClk);
      iHalted = halted; iCmdValid = 1'b1; iCmdWrite = wr;
      iCmdAddr = 5'(addr); iCmdData = data;
      check_eq("cmd_ready", 32'(oCmdReady), 32'd1);
      n_wr0 = n_wr;
      @(posedge iClk); #1;
      iCmdValid = 1'b0;
      iHalted = 1'($urandom_range(0, 1));
      lat = 1;
      while (!oRspValid && lat < 8) begin
         @(posedge iClk); #1;
         lat++;
      end
      check_eq("latency", lat, exp_lat);
      check_eq("rsp_err", 32'(oRspErr), 32'(exp_err));
      check_eq("rsp_data", oRspData, exp_data);

      for (int s = 0; s < int'(stall); s++) begin
         @(negedge iClk);
         iCmdValid = 1'b1; iCmdWrite = 1'b1; iCmdAddr = 5'(addr ^ 1); iCmdData = ~data;
         iHalted = 1'b1;
         check_eq("stall_valid", 32'(oRspValid), 32'd1);
         check_eq("stall_data", oRspData, exp_data);
         check_eq("stall_err", 32'(oRspErr), 32'(exp_err));
         check_eq("stall_ready", 32'(oCmdReady), 32'd0);
      end

      @(negedge iClk);
      iCmdValid = 1'b0; iRspReady = 1'b1;
      @(posedge iClk); #1;
      iRspReady = 1'b0;
      check_eq("rsp_done", 32'(oRspValid), 32'd0);
      check_eq("idle_ready", 32'(oCmdReady), 32'd1);
      check_eq("idle_busy", 32'(oBusy), 32'd0);

      check_eq("wr_pulses", n_wr - n_wr0, (wr && !exp_err) ? 32'd1 : 32'd0);
      if (wr && !exp_err) begin
         check_eq("wr_addr", 32'(wr_addr), addr);
         check_eq("wr_data", wr_data, data);
         if (addr != 0) exp_rf[addr] = data;
      end
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int unsigned n_wr0;
      logic [31:0] old9;

      #1;
      check_eq("rst_ready", 32'(oCmdReady), 32'd1);
      check_eq("rst_valid", 32'(oRspValid), 32'd0);
      check_eq("rst_err", 32'(oRspErr), 32'd0);
      check_eq("rst_data", oRspData, 32'd0);
      check_eq("rst_wen", 32'(oWriteEn_dbg), 32'd0);
      check_eq("rst_rd", 32'(oRd_dbg), 32'd0);
      check_eq("rst_addr_rs", 32'(oAddrRs), 32'd0);
      check_eq("rst_busy", 32'(oBusy), 32'd0);
      repeat (2) @(negedge iClk);
      iRst = 1'b0;

      // Directed cases.
      do_cmd(1'b1, 5, 32'hDEADBEEF, 1'b1, 0);
      do_cmd(1'b0, 5, 32'h0, 1'b1, 0);
      do_cmd(1'b1, 3, 32'hCAFEF00D, 1'b0, 0);
      do_cmd(1'b0, 3, 32'h0, 1'b1, 0);
      do_cmd(1'b0, 20, 32'h0, 1'b1, 0);
      do_cmd(1'b0, 16, 32'h0, 1'b1, 0);
      do_cmd(1'b1, 15, 32'h0F0F0F0F, 1'b1, 0);
      do_cmd(1'b0, 15, 32'h0, 1'b1, 0);
      do_cmd(1'b1, 7, 32'h12345678, 1'b1, 0);
      do_cmd(1'b0, 7, 32'h0, 1'b1, 5);
      do_cmd(1'b1, 0, 32'hFFFFFFFF, 1'b1, 0);
      do_cmd(1'b0, 0, 32'h0, 1'b1, 0);

      // Reset right after a write is accepted: the write must not land.
      do_cmd(1'b1, 9, 32'h11112222, 1'b1, 0);
      old9 = exp_rf[9];
      @(negedge iClk);
      iHalted = 1'b1; iCmdValid = 1'b1; iCmdWrite = 1'b1; iCmdAddr = 5'd9; iCmdData = 32'hBADBAD00;
      n_wr0 = n_wr;
      @(posedge iClk); #1;
      iRst = 1'b1; iCmdValid = 1'b0;
      #1;
      check_eq("abort_wen", 32'(oWriteEn_dbg), 32'd0);
      check_eq("abort_valid", 32'(oRspValid), 32'd0);
      check_eq("abort_ready", 32'(oCmdReady), 32'd1);
      @(negedge iClk);
      iRst = 1'b0;
      repeat (2) @(posedge iClk);
      #1;
      check_eq("abort_pulses", n_wr - n_wr0, 32'd0);
      check_eq("abort_valid2", 32'(oRspValid), 32'd0);
      check_eq("abort_rf", rf[9], old9);
      do_cmd(1'b0, 9, 32'h0, 1'b1, 0);

      // Randomized traffic.
      for (int i = 0; i < 60; i++) begin
         do_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 19), $urandom,
                ($urandom_range(0, 9) < 8), $urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_dbg_reg_access
